// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_pkg
// Brief    : State encoding and counter-width helper shared by pulse_stretcher.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } stretch_state_t;

  // Bits needed to hold max(a, b); never less than 1.
  function automatic int clog2_max(input int a, input int b);
    longint m;
    int     w;
    m = (a > b) ? longint'(a) : longint'(b);
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < (m + 1)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : load_down_counter
// Brief    : Loadable down counter that saturates at zero; load beats dec.
// Revision : 1.0 - initial release
// ============================================================================
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Brief    : Stretches a single-cycle strobe into a HOLD_CYCLES-long level,
//            followed by a GAP_CYCLES forced-low gap. rst is active-low, async.
//            Option macro: PULSE_STRETCHER_RETRIGGER_EN (pulse in HOLD reloads).
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic level_out,
  output logic busy,
  output logic done,
  output logic dropped
);

  localparam int              CNT_W     = clog2_max(HOLD_CYCLES, GAP_CYCLES);
  localparam bit              HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

  stretch_state_t   state;
  stretch_state_t   next_state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;
  logic             reject;

  load_down_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LOAD;
    cnt_dec      = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          accept     = 1'b1;
          next_state = HOLD;
          cnt_load   = 1'b1;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // A retrigger reload wins even on the final hold cycle.
        if (pulse_in) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          if (HAS_GAP) begin
            next_state   = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            next_state = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
`else
        if (cnt_zero) begin
          if (HAS_GAP) begin
            next_state   = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            next_state = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt_zero) begin
          next_state = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign reject = pulse_in && !accept;

  // Outputs are flopped from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      level_out <= (next_state == HOLD);
      busy      <= (next_state != IDLE);
      done      <= (state == HOLD) && (next_state != HOLD);
      dropped   <= reject;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher
// Brief    : Self-checking bench; two DUTs (GAP=2 and GAP=0) against a
//            timestamp-based reference model. Honors PULSE_STRETCHER_RETRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  localparam int H = 4;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse_a = 1'b0;
  logic pulse_b = 1'b0;
  logic level_a, busy_a, done_a, dropped_a;
  logic level_b, busy_b, done_b, dropped_b;
  logic [3:0] obs_a, obs_b;

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(2)) u_dut_gap (
    .clk (clk), .rst (rst), .pulse_in (pulse_a),
    .level_out (level_a), .busy (busy_a), .done (done_a), .dropped (dropped_a)
  );

  pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(0)) u_dut_nogap (
    .clk (clk), .rst (rst), .pulse_in (pulse_b),
    .level_out (level_b), .busy (busy_b), .done (done_b), .dropped (dropped_b)
  );

  assign obs_a = {level_a, busy_a, done_a, dropped_a};
  assign obs_b = {level_b, busy_b, done_b, dropped_b};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: hold spans cycles hs..he, gap spans he+1..he+gap_len.
  int         hs[2];
  int         he[2];
  bit         drop_exp[2];
  int         gap_len[2] = '{2, 0};
  logic [3:0] exp_v[2];

  function automatic int mstate(input int d, input int c);
    if (c >= hs[d] && c <= he[d]) return 1;
    if (c > he[d] && c <= he[d] + gap_len[d]) return 2;
    return 0;
  endfunction

  function automatic logic [3:0] mexp(input int d, input int c);
    int st;
    st = mstate(d, c);
    return {st == 1, st != 0, c == he[d] + 1, drop_exp[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hs[d] = -100;
      he[d] = -100;
      drop_exp[d] = 1'b0;
      exp_v[d] = 4'b0;
    end
  endtask

  task automatic model_edge(input int d, input bit p);
    int st;
    bit acc;
    st  = mstate(d, cyc);
    acc = (st == 0) || (RETRIG && st == 1);
    if (p && acc) begin
      if (st == 0) hs[d] = cyc + 1;
      he[d] = cyc + H;
    end
    drop_exp[d] = p && !acc;
  endtask

  task automatic tick(input bit pa, input bit pb);
    pulse_a = pa;
    pulse_b = pb;
    @(posedge clk);
    model_edge(0, pa);
    model_edge(1, pb);
    cyc++;
    exp_v[0] = mexp(0, cyc);
    exp_v[1] = mexp(1, cyc);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_a !== 4'b0) begin n_fail++; $display("FAIL reset_a got=%b exp=0000", obs_a); end
    n_checks++;
    if (obs_b !== 4'b0) begin n_fail++; $display("FAIL reset_b got=%b exp=0000", obs_b); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (obs_a !== 4'b0) begin n_fail++; $display("FAIL reset_idle_a cyc=%0d got=%b exp=0000", cyc, obs_a); end
      n_checks++;
      if (obs_b !== 4'b0) begin n_fail++; $display("FAIL reset_idle_b cyc=%0d got=%b exp=0000", cyc, obs_b); end
    end
  endtask

  task automatic test_single();
    int lv, bz, dn;
    lv = 0; bz = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick(i == 0, i == 0);
      lv += int'(level_a);
      bz += int'(busy_a);
      dn += int'(done_a);
      n_checks++;
      if (obs_a !== exp_v[0]) begin n_fail++; $display("FAIL single_a i=%0d got=%b exp=%b", i, obs_a, exp_v[0]); end
      n_checks++;
      if (obs_b !== exp_v[1]) begin n_fail++; $display("FAIL single_b i=%0d got=%b exp=%b", i, obs_b, exp_v[1]); end
    end
    n_checks++;
    if (lv !== H) begin n_fail++; $display("FAIL single_level_len got=%0d exp=%0d", lv, H); end
    n_checks++;
    if (bz !== H + 2) begin n_fail++; $display("FAIL single_busy_len got=%0d exp=%0d", bz, H + 2); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    for (int k = 3; k <= 4; k++) begin
      idle_ticks(8);
      for (int i = 0; i < 16; i++) begin
        tick(i == 0 || i == k, i == 0 || i == k);
        if (i == k) begin
          n_checks++;
          if (dropped_a !== !RETRIG) begin
            n_fail++; $display("FAIL b2b_dropped k=%0d got=%b exp=%b", k, dropped_a, !RETRIG);
          end
        end
        n_checks++;
        if (obs_a !== exp_v[0]) begin n_fail++; $display("FAIL b2b_a k=%0d i=%0d got=%b exp=%b", k, i, obs_a, exp_v[0]); end
        n_checks++;
        if (obs_b !== exp_v[1]) begin n_fail++; $display("FAIL b2b_b k=%0d i=%0d got=%b exp=%b", k, i, obs_b, exp_v[1]); end
      end
    end
  endtask

  task automatic test_gap_boundary();
    idle_ticks(8);
    for (int i = 0; i < 16; i++) begin
      tick(i == 0 || i == 6 || i == 7, 1'b0);
      if (i == 6) begin
        n_checks++;
        if (dropped_a !== 1'b1) begin n_fail++; $display("FAIL gap_last_dropped got=%b exp=1", dropped_a); end
      end
      if (i == 7) begin
        n_checks++;
        if (level_a !== 1'b1) begin n_fail++; $display("FAIL gap_reaccept_level got=%b exp=1", level_a); end
      end
      n_checks++;
      if (obs_a !== exp_v[0]) begin n_fail++; $display("FAIL gap_a i=%0d got=%b exp=%b", i, obs_a, exp_v[0]); end
    end
  endtask

  task automatic test_no_gap();
    idle_ticks(8);
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, i == 0 || i == 4 || i == 5);
      n_checks++;
      if (obs_b !== exp_v[1]) begin n_fail++; $display("FAIL nogap_b i=%0d got=%b exp=%b", i, obs_b, exp_v[1]); end
    end
  endtask

  task automatic test_async_reset();
    idle_ticks(8);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 4'b0) begin n_fail++; $display("FAIL async_rst_a got=%b exp=0000", obs_a); end
    n_checks++;
    if (obs_b !== 4'b0) begin n_fail++; $display("FAIL async_rst_b got=%b exp=0000", obs_b); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick(i == 2, i == 2);
      n_checks++;
      if (obs_a !== exp_v[0]) begin n_fail++; $display("FAIL async_post_a i=%0d got=%b exp=%b", i, obs_a, exp_v[0]); end
      n_checks++;
      if (obs_b !== exp_v[1]) begin n_fail++; $display("FAIL async_post_b i=%0d got=%b exp=%b", i, obs_b, exp_v[1]); end
    end
  endtask

  task automatic test_random();
    bit pa, pb;
    for (int i = 0; i < 600; i++) begin
      pa = ($urandom_range(0, 3) == 0);
      pb = ($urandom_range(0, 2) == 0);
      tick(pa, pb);
      n_checks++;
      if (obs_a !== exp_v[0]) begin n_fail++; $display("FAIL random_a i=%0d got=%b exp=%b", i, obs_a, exp_v[0]); end
      n_checks++;
      if (obs_b !== exp_v[1]) begin n_fail++; $display("FAIL random_b i=%0d got=%b exp=%b", i, obs_b, exp_v[1]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_boundary();
    test_no_gap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
